medikit_ctrl: RTL
=================

MEDIKIT_CTRL -- requirements
Module: medikit_ctrl

Interface
REQ-001 Parameter CLK_DIV, 50000000: clock cycles per 1 s tick.
REQ-002 Parameter INTERVAL_S, 28800: seconds between doses.
REQ-003 Parameter PREWARN_S, 60: pre-warning window before dose; 1 <= PREWARN_S < INTERVAL_S.
REQ-004 Parameter SNOOZE_S, 300: snooze length in seconds.
REQ-005 Parameter RING_S, 60: length of each ringing phase in seconds.
REQ-006 Parameter MAX_SNOOZE, 3: snoozes allowed per dose.
REQ-007 Parameter TAKEN_S, 2: seconds the TAKEN confirmation is held.
REQ-008 clk  in  1  system clock; sole clock; all state changes on its rising edge.
REQ-009 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-010 btn_set  in  1  arm/disarm button; synchronous, debounced level.
REQ-011 btn_ack  in  1  dose-taken button; synchronous, debounced level.
REQ-012 btn_snooze  in  1  snooze button; synchronous, debounced level.
REQ-013 lid_open  in  1  kit lid sensor; rising edge counts as acknowledge.
REQ-014 sta  out  4  controller state code; drives the LED display stage.
REQ-015 remain  out  16  seconds left in the current timed phase.
REQ-016 dose_cnt  out  8  doses taken, saturating at 255.
REQ-017 miss_cnt  out  8  doses missed, saturating at 255.
REQ-018 buzzer  out  1  alarm sounder enable.

Function
REQ-019 All outputs SHALL be registered; inputs act only on a rising edge (high now, low in previous cycle); response visible on the sampling clock edge.
REQ-020 sta codes SHALL be: IDLE=0, ARMED=1, PREWARN=2, SNOOZE=3, TAKEN=4, RING=6, RING_LAST=7, MISSED=8; codes 5 and 9-15 are never driven.
REQ-021 Same-cycle priority SHALL be: set > ack (btn_ack or lid_open) > snooze > tick.
REQ-022 IDLE: set -> ARMED, remain=INTERVAL_S, snooze counter=0; all other events ignored.
REQ-023 Any non-IDLE state: set -> IDLE, remain=0, buzzer=0.
REQ-024 ARMED/PREWARN/SNOOZE/RING/RING_LAST: each tick decrements remain by 1; remain never wraps below 0.
REQ-025 ARMED: tick leaving remain==PREWARN_S -> PREWARN; ack ignored.
REQ-026 PREWARN: ack -> TAKEN (early dose); tick leaving remain==0 -> RING, remain=RING_S.
REQ-027 RING: ack -> TAKEN; snooze with snooze counter < MAX_SNOOZE -> SNOOZE, remain=SNOOZE_S, counter+1; snooze at limit ignored; tick leaving remain==0 -> RING_LAST, remain=RING_S.
REQ-028 SNOOZE: ack -> TAKEN; tick leaving remain==0 -> RING, remain=RING_S.
REQ-029 RING_LAST: snooze ignored; ack -> TAKEN; tick leaving remain==0 -> MISSED, remain=0, miss_cnt+1 (saturating).
REQ-030 TAKEN: entry increments dose_cnt (saturating); remain=TAKEN_S on entry; tick leaving remain==0 -> ARMED, remain=INTERVAL_S, snooze counter=0.
REQ-031 MISSED: ack -> ARMED, remain=INTERVAL_S, snooze counter=0; no dose_cnt change.
REQ-032 buzzer SHALL be 1 exactly while sta is RING or RING_LAST.
REQ-033 Tick SHALL be a one-cycle pulse every CLK_DIV cycles, free-running from reset.

Reset
REQ-034 rst_n low SHALL immediately force sta=IDLE, remain=0, dose_cnt=0, miss_cnt=0, buzzer=0, snooze counter=0, tick divider=0, edge-detect history=0.
REQ-035 A button held high across reset release SHALL register as a rising edge on the first clock edge after release.

Structure
REQ-036 State codes and parameter defaults SHALL live in package medikit_pkg, shared with the LED display stage.
REQ-037 The 1 s divider SHALL be sub-module tick_gen (ports clk, rst_n, tick; parameter CLK_DIV).

Verification (CLK_DIV=4, INTERVAL_S=10, PREWARN_S=3, SNOOZE_S=5, RING_S=4, MAX_SNOOZE=2, TAKEN_S=2)
REQ-038 Set pulse -> sta=1, remain=10; after 7 ticks sta=2, remain=3; after 3 more ticks sta=6, remain=4, buzzer=1.
REQ-039 In RING, btn_ack pulse -> sta=4, dose_cnt=1; after 2 ticks sta=1, remain=10.
REQ-040 In RING, snooze -> sta=3, remain=5; after 5 ticks sta=6; snooze -> sta=3; after 5 ticks the 3rd snooze is ignored, sta stays 6.
REQ-041 No response in RING: after 4 ticks sta=7; after 4 more ticks sta=8, miss_cnt=1, buzzer=0.
REQ-042 lid_open edge on the same cycle as the tick that ends RING (remain=1) -> sta=4, not 7.
REQ-043 rst_n low mid-RING -> sta=0, buzzer=0, remain=0, dose_cnt=0 with no clock edge.

Source files
------------

// File: rtl/medikit_pkg.sv
// Shared definitions for the medication kit controller and its LED display stage:
// state codes, parameter defaults and small saturating arithmetic helpers.
package medikit_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ARMED     = 4'd1,
    ST_PREWARN   = 4'd2,
    ST_SNOOZE    = 4'd3,
    ST_TAKEN     = 4'd4,
    ST_RING      = 4'd6,
    ST_RING_LAST = 4'd7,
    ST_MISSED    = 4'd8
  } state_e;

  localparam int DEF_CLK_DIV    = 50000000;
  localparam int DEF_INTERVAL_S = 28800;
  localparam int DEF_PREWARN_S  = 60;
  localparam int DEF_SNOOZE_S   = 300;
  localparam int DEF_RING_S     = 60;
  localparam int DEF_MAX_SNOOZE = 3;
  localparam int DEF_TAKEN_S    = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] dec_sat16(input logic [15:0] v);
    return (v == 16'd0) ? v : v - 16'd1;
  endfunction

endpackage

// File: rtl/medikit_if.sv
// Button inputs and status outputs of the medication kit controller.
interface medikit_if;
  logic        btn_set;
  logic        btn_ack;
  logic        btn_snooze;
  logic        lid_open;
  logic [3:0]  sta;
  logic [15:0] remain;
  logic [7:0]  dose_cnt;
  logic [7:0]  miss_cnt;
  logic        buzzer;

  modport master (
    output btn_set, btn_ack, btn_snooze, lid_open,
    input  sta, remain, dose_cnt, miss_cnt, buzzer
  );

  modport slave (
    input  btn_set, btn_ack, btn_snooze, lid_open,
    output sta, remain, dose_cnt, miss_cnt, buzzer
  );
endinterface

// File: rtl/medikit_tick_gen.sv
// Free-running divider producing a one-cycle pulse every CLK_DIV clocks.
module tick_gen #(
  parameter int CLK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);
endmodule

// File: rtl/medikit_ctrl.sv
// Dose reminder controller: countdown to each dose, pre-warning, ringing with
// limited snoozes, confirmation and miss accounting.
module medikit_ctrl
  import medikit_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int INTERVAL_S = DEF_INTERVAL_S,
  parameter int PREWARN_S  = DEF_PREWARN_S,
  parameter int SNOOZE_S   = DEF_SNOOZE_S,
  parameter int RING_S     = DEF_RING_S,
  parameter int MAX_SNOOZE = DEF_MAX_SNOOZE,
  parameter int TAKEN_S    = DEF_TAKEN_S
) (
  input logic       clk,
  input logic       rst_n,
  medikit_if.slave  kit
);
  localparam logic [15:0] REM_INTERVAL = 16'(INTERVAL_S);
  localparam logic [15:0] REM_PREWARN  = 16'(PREWARN_S);
  localparam logic [15:0] REM_SNOOZE   = 16'(SNOOZE_S);
  localparam logic [15:0] REM_RING     = 16'(RING_S);
  localparam logic [15:0] REM_TAKEN    = 16'(TAKEN_S);
  localparam logic [7:0]  SNZ_LIMIT    = 8'(MAX_SNOOZE);

  state_e      state_q, state_d;
  logic [15:0] remain_q, remain_d;
  logic [7:0]  dose_q, dose_d;
  logic [7:0]  miss_q, miss_d;
  logic [7:0]  snz_q, snz_d;
  logic        buzzer_q, buzzer_d;
  logic [3:0]  hist_q;
  logic [3:0]  in_vec;
  logic [3:0]  rise;
  logic        tick;
  logic        set_ev, ack_ev, snz_ev, alerting;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign in_vec = {kit.lid_open, kit.btn_snooze, kit.btn_ack, kit.btn_set};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_edge
      assign rise[gi] = in_vec[gi] & ~hist_q[gi];
    end
  endgenerate

  assign set_ev   = rise[0];
  assign ack_ev   = rise[1] | rise[3];
  assign snz_ev   = rise[2];
  assign alerting = state_q inside {ST_PREWARN, ST_SNOOZE, ST_RING, ST_RING_LAST};

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    dose_d   = dose_q;
    miss_d   = miss_q;
    snz_d    = snz_q;
    // Only the highest-priority event that the current state honours takes effect.
    if (state_q == ST_IDLE) begin
      if (set_ev) begin
        state_d  = ST_ARMED;
        remain_d = REM_INTERVAL;
        snz_d    = '0;
      end
    end else if (set_ev) begin
      state_d  = ST_IDLE;
      remain_d = '0;
    end else if (ack_ev && alerting) begin
      state_d  = ST_TAKEN;
      remain_d = REM_TAKEN;
      dose_d   = sat_inc8(dose_q);
    end else if (ack_ev && state_q == ST_MISSED) begin
      state_d  = ST_ARMED;
      remain_d = REM_INTERVAL;
      snz_d    = '0;
    end else if (snz_ev && state_q == ST_RING && snz_q < SNZ_LIMIT) begin
      state_d  = ST_SNOOZE;
      remain_d = REM_SNOOZE;
      snz_d    = snz_q + 8'd1;
    end else if (tick) begin
      remain_d = dec_sat16(remain_q);
      case (state_q)
        ST_ARMED: begin
          if (remain_d == REM_PREWARN) state_d = ST_PREWARN;
        end
        ST_PREWARN, ST_SNOOZE: begin
          if (remain_d == 16'd0) begin
            state_d  = ST_RING;
            remain_d = REM_RING;
          end
        end
        ST_RING: begin
          if (remain_d == 16'd0) begin
            state_d  = ST_RING_LAST;
            remain_d = REM_RING;
          end
        end
        ST_RING_LAST: begin
          if (remain_d == 16'd0) begin
            state_d = ST_MISSED;
            miss_d  = sat_inc8(miss_q);
          end
        end
        ST_TAKEN: begin
          if (remain_d == 16'd0) begin
            state_d  = ST_ARMED;
            remain_d = REM_INTERVAL;
            snz_d    = '0;
          end
        end
        default: remain_d = remain_q;
      endcase
    end
    buzzer_d = (state_d == ST_RING) || (state_d == ST_RING_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      dose_q   <= '0;
      miss_q   <= '0;
      snz_q    <= '0;
      buzzer_q <= 1'b0;
      hist_q   <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      dose_q   <= dose_d;
      miss_q   <= miss_d;
      snz_q    <= snz_d;
      buzzer_q <= buzzer_d;
      hist_q   <= in_vec;
    end
  end

  assign kit.sta      = state_q;
  assign kit.remain   = remain_q;
  assign kit.dose_cnt = dose_q;
  assign kit.miss_cnt = miss_q;
  assign kit.buzzer   = buzzer_q;
endmodule
